// File: rtl/data_bus_responder.sv
// Data-memory bus responder: word RAM with byte-lane stores plus an MMIO window
// holding a console TX FIFO, a 64-bit cycle counter and a sticky fault register.
module data_bus_responder #(
   parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
   parameter int unsigned MEM_WORDS  = 1024,
   parameter logic [31:0] MMIO_BASE  = 32'h4000_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] bus_address,
   input  logic [31:0] bus_write_data,
   input  logic [3:0]  bus_byte_enable,
   input  logic        bus_read_enable,
   input  logic        bus_write_enable,
   output logic [31:0] bus_read_data,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready,
   output logic        fault
);

   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [2:0] {
      REG_TX     = 3'd0,
      REG_STATUS = 3'd1,
      REG_CYC_LO = 3'd2,
      REG_CYC_HI = 3'd3,
      REG_FAULT  = 3'd4
   } mmio_reg_e;

   logic [31:0] r_mem [MEM_WORDS];
   logic [7:0]  r_fifo [FIFO_DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic        r_overflow;
   logic [63:0] r_cycle;
   logic        r_fault;
   logic [31:0] r_fault_addr;

   logic [29:0]   w_ram_off;
   logic [29:0]   w_mmio_off;
   logic          w_ram_hit;
   logic          w_mmio_hit;
   logic [2:0]    w_reg;
   logic [AW-1:0] w_ram_idx;
   logic          w_wr;
   logic          w_push;
   logic          w_pop;
   logic          w_push_ok;
   logic          w_full;
   logic          w_empty;
   logic          w_bad;
   logic [4:0]    w_count5;
   logic [31:0]   w_rdata;
   logic          w_unused;

   // Offsets are taken on word addresses so the wrapped subtraction doubles as a range check.
   assign w_ram_off  = bus_address[31:2] - MEM_BASE[31:2];
   assign w_mmio_off = bus_address[31:2] - MMIO_BASE[31:2];
   assign w_ram_hit  = (w_ram_off < 30'(MEM_WORDS));
   assign w_mmio_hit = (w_mmio_off < 30'd8);
   assign w_reg      = w_mmio_off[2:0];
   assign w_ram_idx  = w_ram_off[AW-1:0];
   assign w_unused   = ^{bus_address[1:0], w_ram_off[29:AW], w_mmio_off[29:3]};

   assign w_wr      = bus_write_enable && (bus_byte_enable != 4'b0000);
   assign w_push    = w_wr && w_mmio_hit && (w_reg == REG_TX) && bus_byte_enable[0];
   assign w_full    = (r_count == CW'(FIFO_DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_pop     = !w_empty && out_ready;
   assign w_push_ok = w_push && (!w_full || w_pop);
   assign w_bad     = (bus_read_enable || bus_write_enable) && !w_ram_hit && !w_mmio_hit;
   assign w_count5  = 5'(r_count);

   always_comb begin
      w_rdata = '0;
      if (bus_read_enable) begin
         if (w_ram_hit) begin
            w_rdata = r_mem[w_ram_idx];
         end else if (w_mmio_hit) begin
            case (w_reg)
               REG_STATUS: w_rdata = {23'd0, w_count5, 1'b0, r_overflow, w_empty, w_full};
               REG_CYC_LO: w_rdata = r_cycle[31:0];
               REG_CYC_HI: w_rdata = r_cycle[63:32];
               REG_FAULT:  w_rdata = r_fault_addr;
               default:    w_rdata = '0;
            endcase
         end
      end
   end

   assign bus_read_data = w_rdata;
   assign out_valid     = !w_empty;
   assign out_data      = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
   assign fault         = r_fault;

   always_ff @(posedge clock) begin
      if (!reset && bus_write_enable && w_ram_hit) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (bus_byte_enable[i]) r_mem[w_ram_idx][8*i +: 8] <= bus_write_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= bus_write_data[7:0];
            r_wr_ptr         <= r_wr_ptr + PW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
         if (w_push_ok && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push_ok && w_pop) r_count <= r_count - CW'(1);
         if (w_push && !w_push_ok)
            r_overflow <= 1'b1;
         else if (w_wr && w_mmio_hit && (w_reg == REG_STATUS))
            r_overflow <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) r_cycle <= '0;
      else       r_cycle <= r_cycle + 64'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_fault      <= 1'b0;
         r_fault_addr <= '0;
      end else if (w_bad) begin
         r_fault <= 1'b1;
         if (!r_fault) r_fault_addr <= bus_address;
      end else if (w_wr && w_mmio_hit && (w_reg == REG_FAULT)) begin
         r_fault      <= 1'b0;
         r_fault_addr <= '0;
      end
   end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: RAM lanes, FIFO, counter, fault and reset.
module tb_data_bus_responder;

   localparam logic [31:0] MMIO   = 32'h4000_0000;
   localparam logic [31:0] A_TX   = MMIO + 32'h00;
   localparam logic [31:0] A_ST   = MMIO + 32'h04;
   localparam logic [31:0] A_LO   = MMIO + 32'h08;
   localparam logic [31:0] A_HI   = MMIO + 32'h0C;
   localparam logic [31:0] A_FA   = MMIO + 32'h10;

   logic        clock;
   logic        reset;
   logic [31:0] bus_address;
   logic [31:0] bus_write_data;
   logic [3:0]  bus_byte_enable;
   logic        bus_read_enable;
   logic        bus_write_enable;
   logic [31:0] bus_read_data;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        fault;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [7:0]  exp_bytes [4];

   data_bus_responder #(
      .MEM_BASE  (32'h8000_0000),
      .MEM_WORDS (1024),
      .MMIO_BASE (32'h4000_0000),
      .FIFO_DEPTH(4)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .bus_address     (bus_address),
      .bus_write_data  (bus_write_data),
      .bus_byte_enable (bus_byte_enable),
      .bus_read_enable (bus_read_enable),
      .bus_write_enable(bus_write_enable),
      .bus_read_data   (bus_read_data),
      .out_valid       (out_valid),
      .out_data        (out_data),
      .out_ready       (out_ready),
      .fault           (fault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clock);
      bus_address      = a;
      bus_write_data   = d;
      bus_byte_enable  = be;
      bus_write_enable = 1'b1;
      @(posedge clock);
      #1;
      bus_write_enable = 1'b0;
      bus_byte_enable  = 4'b0000;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      @(negedge clock);
      bus_address     = a;
      bus_read_enable = 1'b1;
      #1;
      chk(tag, bus_read_data, exp);
      @(posedge clock);
      #1;
      bus_read_enable = 1'b0;
   endtask

   task automatic drain(input string tag);
      @(negedge clock);
      out_ready = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_data"}, 32'(out_data), 32'(exp_bytes[i]));
         @(negedge clock);
         #1;
      end
      chk({tag, "_empty"}, 32'(out_valid), 32'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      reset            = 1'b1;
      bus_address      = '0;
      bus_write_data   = '0;
      bus_byte_enable  = '0;
      bus_read_enable  = 1'b0;
      bus_write_enable = 1'b0;
      out_ready        = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);

      // counter relative to reset release
      reset           = 1'b0;
      bus_address     = A_LO;
      bus_read_enable = 1'b1;
      #1 chk("cyc0", bus_read_data, 32'd0);
      @(negedge clock);
      #1 chk("cyc1", bus_read_data, 32'd1);
      repeat (4) @(negedge clock);
      #1 chk("cyc5", bus_read_data, 32'd5);

      // LO -> HI carry
      @(negedge clock);
      force dut.r_cycle = 64'h0000_0000_FFFF_FFFF;
      #1 release dut.r_cycle;
      bus_address = A_LO;
      #1 chk("carry_lo_pre", bus_read_data, 32'hFFFF_FFFF);
      bus_address = A_HI;
      #1 chk("carry_hi_pre", bus_read_data, 32'h0000_0000);
      @(negedge clock);
      #1 chk("carry_hi", bus_read_data, 32'h0000_0001);
      bus_address = A_LO;
      #1 chk("carry_lo", bus_read_data, 32'h0000_0000);

      // full 64-bit wrap
      @(negedge clock);
      force dut.r_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
      #1 release dut.r_cycle;
      bus_address = A_HI;
      #1 chk("wrap_hi_pre", bus_read_data, 32'hFFFF_FFFF);
      @(negedge clock);
      #1 chk("wrap_hi", bus_read_data, 32'h0000_0000);
      bus_address = A_LO;
      #1 chk("wrap_lo", bus_read_data, 32'h0000_0000);
      bus_read_enable = 1'b0;

      // RAM byte lanes
      wr(32'h8000_0010, 32'h1122_3344, 4'b1111);
      wr(32'h8000_0010, 32'h0000_AA00, 4'b0010);
      rd("ram_lane", 32'h8000_0010, 32'h1122_AA44);
      wr(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000);
      rd("ram_be0", 32'h8000_0010, 32'h1122_AA44);
      rd("ram_lowbits", 32'h8000_0013, 32'h1122_AA44);
      wr(32'h8000_0FFC, 32'hDEAD_BEEF, 4'b1111);
      rd("ram_last", 32'h8000_0FFC, 32'hDEAD_BEEF);
      chk("ram_last_nofault", 32'(fault), 32'd0);
      rd("read_disabled_addr", 32'h8000_0FFC, 32'hDEAD_BEEF);
      @(negedge clock);
      bus_address = 32'h8000_0FFC;
      #1 chk("read_en_low", bus_read_data, 32'h0);

      // same-cycle read and write
      wr(32'h8000_0000, 32'h0000_0005, 4'b1111);
      @(negedge clock);
      bus_address      = 32'h8000_0000;
      bus_write_data   = 32'h0000_0009;
      bus_byte_enable  = 4'b1111;
      bus_write_enable = 1'b1;
      bus_read_enable  = 1'b1;
      #1 chk("rw_old", bus_read_data, 32'h0000_0005);
      @(posedge clock);
      #1;
      bus_write_enable = 1'b0;
      bus_read_enable  = 1'b0;
      rd("rw_new", 32'h8000_0000, 32'h0000_0009);

      // FIFO fill, overflow, drain
      rd("st_empty0", A_ST, 32'h0000_0002);
      wr(A_TX, 32'h41, 4'b0001);
      wr(A_TX, 32'h42, 4'b0001);
      wr(A_TX, 32'h43, 4'b0001);
      wr(A_TX, 32'h44, 4'b0001);
      rd("st_full", A_ST, 32'h0000_0041);
      rd("tx_reads0", A_TX, 32'h0);
      wr(A_TX, 32'h45, 4'b0001);
      rd("st_ovf", A_ST, 32'h0000_0045);
      chk("head_hold", 32'(out_data), 32'h41);
      wr(A_ST, 32'h0, 4'b1111);
      rd("st_ovf_clr", A_ST, 32'h0000_0041);
      exp_bytes[0] = 8'h41; exp_bytes[1] = 8'h42; exp_bytes[2] = 8'h43; exp_bytes[3] = 8'h44;
      drain("drain1");
      rd("st_empty1", A_ST, 32'h0000_0002);

      // full + push + pop in one cycle
      wr(A_TX, 32'h50, 4'b0001);
      wr(A_TX, 32'h51, 4'b0001);
      wr(A_TX, 32'h52, 4'b0001);
      wr(A_TX, 32'h53, 4'b0001);
      @(negedge clock);
      bus_address      = A_TX;
      bus_write_data   = 32'h5A;
      bus_byte_enable  = 4'b0001;
      bus_write_enable = 1'b1;
      out_ready        = 1'b1;
      @(posedge clock);
      #1;
      bus_write_enable = 1'b0;
      bus_byte_enable  = 4'b0000;
      out_ready        = 1'b0;
      rd("st_pushpop", A_ST, 32'h0000_0041);
      exp_bytes[0] = 8'h51; exp_bytes[1] = 8'h52; exp_bytes[2] = 8'h53; exp_bytes[3] = 8'h5A;
      drain("drain2");

      // fault capture and clear
      rd("bad_rd", 32'h0000_1000, 32'h0);
      chk("fault_set", 32'(fault), 32'd1);
      rd("fa_first", A_FA, 32'h0000_1000);
      rd("bad_rd2", 32'h0000_2000, 32'h0);
      rd("fa_kept", A_FA, 32'h0000_1000);
      wr(A_FA, 32'h0, 4'b1111);
      chk("fault_clr", 32'(fault), 32'd0);
      rd("fa_clr", A_FA, 32'h0);
      rd("ram_end", 32'h8000_1000, 32'h0);
      chk("ram_end_fault", 32'(fault), 32'd1);
      rd("fa_ram_end", A_FA, 32'h8000_1000);
      wr(A_FA, 32'h0, 4'b1111);
      rd("mmio_rsvd", MMIO + 32'h14, 32'h0);
      chk("rsvd_nofault", 32'(fault), 32'd0);

      // reset with bytes pending
      wr(A_TX, 32'h61, 4'b0001);
      wr(A_TX, 32'h62, 4'b0001);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      bus_address     = A_LO;
      bus_read_enable = 1'b1;
      #1;
      chk("rst2_valid", 32'(out_valid), 32'd0);
      chk("rst2_data", 32'(out_data), 32'd0);
      chk("rst2_cycle", bus_read_data, 32'd0);
      @(posedge clock);
      #1 bus_read_enable = 1'b0;
      rd("rst2_status", A_ST, 32'h0000_0002);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
